// File: rtl/rs_syndrome_5.sv
// rtl/rs_syndrome_5.sv - GF(2^5) Reed-Solomon S1/S2 syndrome accumulator (optional framing checks: RS_SYN_FRAME_CHECK_EN)
module rs_syndrome_5 #(
    parameter int N_SYM = 31
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] sym_i,
    input  logic       sym_valid_i,
    input  logic       sof_i,
    output logic       sym_ready_o,
    output logic [9:0] syn_o,
    output logic       syn_valid_o,
    input  logic       syn_ready_i,
    output logic       err_o,
    output logic       frame_err_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [4:0] N_LAST = 5'(N_SYM);

    state_t     state;
    logic [4:0] count;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       sym_ready;
    logic       syn_valid;
    logic [4:0] count_nxt;
    logic [4:0] s1_nxt;
    logic [4:0] s2_nxt;

    // Multiply by alpha: shift up, fold x^5 back in as x^2+1.
    function automatic logic [4:0] mul_alpha(input logic [4:0] x);
        return {x[3:0], 1'b0} ^ (x[4] ? 5'b00101 : 5'b00000);
    endfunction

    assign count_nxt = count + 5'd1;
    assign s1_nxt    = mul_alpha(s1) ^ sym_i;
    assign s2_nxt    = mul_alpha(mul_alpha(s2)) ^ sym_i;

    assign sym_ready_o = sym_ready;
    assign syn_valid_o = syn_valid;
    assign syn_o       = {s2, s1};
    assign err_o       = (s1 != 5'd0) || (s2 != 5'd0);

`ifdef RS_SYN_FRAME_CHECK_EN
    logic frame_err;
    assign frame_err_o = frame_err;

    // Framing violations raise a single-cycle pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= sym_valid_i && sym_ready &&
                         ((state == IDLE && !sof_i) || (state == ACCUM && sof_i));
        end
    end
`else
    assign frame_err_o = 1'b0;
`endif

    // Codeword sequencer: accumulate N_SYM symbols, then hold result until consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= 5'd0;
            s1        <= 5'd0;
            s2        <= 5'd0;
            sym_ready <= 1'b1;
            syn_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sym_valid_i && sof_i) begin
                        s1    <= sym_i;
                        s2    <= sym_i;
                        count <= 5'd1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sym_valid_i) begin
`ifdef RS_SYN_FRAME_CHECK_EN
                        if (sof_i) begin
                            s1    <= sym_i;
                            s2    <= sym_i;
                            count <= 5'd1;
                        end else
`endif
                        begin
                            s1    <= s1_nxt;
                            s2    <= s2_nxt;
                            count <= count_nxt;
                            if (count_nxt == N_LAST) begin
                                state     <= HOLD;
                                sym_ready <= 1'b0;
                                syn_valid <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (syn_ready_i) begin
                        state     <= IDLE;
                        count     <= 5'd0;
                        sym_ready <= 1'b1;
                        syn_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= 5'd0;
                    sym_ready <= 1'b1;
                    syn_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rs_syndrome_5.md
RS_SYNDROME_5 -- requirements
Module: rs_syndrome_5

Interface
REQ-001 SHALL have parameter N_SYM, default 31, symbols per codeword (legal 3..31).
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sym_i  input  5  GF(2^5) codeword symbol, highest-degree first.
REQ-005 SHALL have port sym_valid_i  input  1  sym_i valid.
REQ-006 SHALL have port sof_i  input  1  qualifies first symbol of a codeword.
REQ-007 SHALL have port sym_ready_o  output  1  symbol accepted when sym_valid_i & sym_ready_o.
REQ-008 SHALL have port syn_o  output  10  [4:0]=S1, [9:5]=S2.
REQ-009 SHALL have port syn_valid_o  output  1  syn_o/err_o valid.
REQ-010 SHALL have port syn_ready_i  input  1  consumer accepts syndromes.
REQ-011 SHALL have port err_o  output  1  high when S1 or S2 nonzero.
REQ-012 SHALL have port frame_err_o  output  1  one-cycle framing-violation pulse.

Function
REQ-013 SHALL use GF(2^5) with primitive polynomial x^5+x^2+1, alpha = 0b00010; constant multipliers purely combinational.
REQ-014 SHALL compute by Horner: S1 <= S1*alpha ^ sym_i, S2 <= S2*alpha^2 ^ sym_i per accepted symbol.
REQ-015 SHALL implement states IDLE, ACCUM, HOLD; sym_ready_o = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-016 IDLE: accepted symbol with sof_i=1 SHALL load S1=S2=sym_i, count=1, go ACCUM; accepted symbol with sof_i=0 SHALL be discarded.
REQ-017 ACCUM: each accepted symbol SHALL update syndromes and increment count; when count reaches N_SYM, SHALL enter HOLD the next cycle.
REQ-018 Gaps (sym_valid_i=0) SHALL leave state, count, and syndromes unchanged.
REQ-019 HOLD: syn_valid_o=1 with syn_o/err_o stable until syn_ready_i=1, then go IDLE the next cycle; latency last symbol -> syn_valid_o = 1 cycle.
REQ-020 syn_valid_o SHALL be 0 outside HOLD; syn_o SHALL show running syndromes at all times.
REQ-021 Count SHALL be 5 bits, never wrap past N_SYM.

Reset
REQ-022 rstn=0 SHALL asynchronously force IDLE, count=0, S1=S2=0, syn_valid_o=0, frame_err_o=0, err_o=0, sym_ready_o=1 once released.
REQ-023 Reset mid-codeword or in HOLD SHALL discard partial/pending syndromes; first post-reset codeword SHALL need sof_i.

Configuration
REQ-024 Macro RS_SYN_FRAME_CHECK_EN SHALL enable framing checks.
REQ-025 With RS_SYN_FRAME_CHECK_EN: sof_i on accepted symbol in ACCUM SHALL restart (load as REQ-016) and pulse frame_err_o; non-sof symbol in IDLE SHALL pulse frame_err_o.
REQ-026 Without RS_SYN_FRAME_CHECK_EN: sof_i in ACCUM SHALL be ignored (ordinary data); frame_err_o SHALL be constant 0.

Verification
REQ-027 31 zero symbols, sof on first -> syn_o=0x000, err_o=0, syn_valid_o 1 cycle after 31st.
REQ-028 sym 0x01 first (sof), 30 zeros -> S1=0x12, S2=0x09, err_o=1.
REQ-029 30 zeros (sof first), last 0x01 -> S1=0x01, S2=0x01, err_o=1.
REQ-030 syn_ready_i low 5 cycles in HOLD -> syn_valid_o, syn_o stable, sym_ready_o=0; released -> IDLE next cycle.
REQ-031 sof at symbol 10 (macro on) -> frame_err_o pulse, codeword completes 31 symbols after restart; macro off -> no pulse, completes at symbol 31.
REQ-032 rstn low at symbol 15 -> all outputs at reset values; next sof codeword gives correct syndromes.
